muldiv_ctrl: RTL

- Sequencer for an iterative radix-2 multiply/divide datapath that owns the HI/LO register pair of the MIPS core.
- Sits beside the ALU in EX. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the decode/ALU-control path.
- It raises busy while an operation is in flight so the hazard unit stalls MFHI/MFLO and further mul/div issue.

---
 rtl/muldiv_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for an iterative radix-2 multiply/divide unit.
// Build option: define MULDIV_EARLY_EXIT_EN to end MUL once the multiplier is exhausted.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]     hi_reg, hi_next;
    logic [WIDTH-1:0]     lo_reg, lo_next;
    // acc holds the product for multiply and {remainder, quotient} for divide
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic                 sign_reg, sign_next;
    logic                 rsign_reg, rsign_next;
    logic                 is_div_reg, is_div_next;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [CNT_W-1:0]     cnt_inc;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     rem_fixed;
    logic [WIDTH-1:0]     quot_fixed;

    // MULT and DIV have an even function code; the unsigned forms are odd
    assign signed_op = ~func[0];
    assign a_abs     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_abs     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_reg[WIDTH-1:0]};
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    assign prod_fixed = sign_reg  ? -acc_reg : acc_reg;
    assign rem_fixed  = rsign_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    assign quot_fixed = sign_reg  ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            sign_reg   <= 1'b0;
            rsign_reg  <= 1'b0;
            is_div_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            sign_reg   <= sign_next;
            rsign_reg  <= rsign_next;
            is_div_reg <= is_div_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        sign_next   = sign_reg;
        rsign_next  = rsign_reg;
        is_div_next = is_div_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (func)
                        FN_MTHI: hi_next = op_a;
                        FN_MTLO: lo_next = op_a;
                        FN_MULT, FN_MULTU: begin
                            acc_next    = '0;
                            mcand_next  = {{WIDTH{1'b0}}, a_abs};
                            mplier_next = b_abs;
                            sign_next   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            rsign_next  = 1'b0;
                            is_div_next = 1'b0;
                            cnt_next    = '0;
                            state_next  = ST_MUL;
                        end
                        FN_DIV, FN_DIVU: begin
                            is_div_next = 1'b1;
                            cnt_next    = '0;
                            if (op_b == '0) begin
                                // divide by zero: raw dividend to HI, all-ones to LO, no fixup
                                acc_next   = {op_a, {WIDTH{1'b1}}};
                                sign_next  = 1'b0;
                                rsign_next = 1'b0;
                                state_next = ST_FIX;
                            end else begin
                                acc_next   = {{WIDTH{1'b0}}, a_abs};
                                mcand_next = {{WIDTH{1'b0}}, b_abs};
                                sign_next  = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                rsign_next = signed_op & op_a[WIDTH-1];
                                state_next = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    if (mplier_reg[0]) begin
                        acc_next = acc_reg + mcand_reg;
                    end
                    mcand_next  = mcand_reg << 1;
                    mplier_next = mplier_reg >> 1;
                    cnt_next    = cnt_inc;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_FIX;
                    end
`ifdef MULDIV_EARLY_EXIT_EN
                    if ((mplier_reg >> 1) == '0) begin
                        state_next = ST_FIX;
                    end
`endif
                end
            end

            ST_DIV: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    // restoring step: keep the trial difference only when it did not borrow
                    if (!div_diff[WIDTH]) begin
                        acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
                    end
                    cnt_next = cnt_inc;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    if (is_div_reg) begin
                        hi_next = rem_fixed;
                        lo_next = quot_fixed;
                    end else begin
                        hi_next = prod_fixed[2*WIDTH-1:WIDTH];
                        lo_next = prod_fixed[WIDTH-1:0];
                    end
                    state_next = ST_DONE;
                end
            end

            ST_DONE: state_next = ST_IDLE;

            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_MUL) || (state_reg == ST_DIV) || (state_reg == ST_FIX);
    assign done = (state_reg == ST_DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
